// File: rtl/cpu_mem_ctrl.sv
// rtl/cpu_mem_ctrl.sv - sequencer/arbiter for the single-port CPU packet memory
//
// Shares the memory's one RW port between host byte writes and a packet
// streamer that reads a committed packet out as a byte stream. Absorbs the
// memory's two-cycle read latency with a 2-stage in-flight tracker and a
// 4-entry output FIFO so the stream output is backpressure safe.
//
// Ports:
//   clk0, rst0                    clock, synchronous active-high reset
//   h_wr_valid/ready/addr/data    host write request and combinational grant
//   pkt_go/base/len               start a packet stream (sampled on pkt_go in IDLE)
//   pkt_busy, pkt_done            packet in progress / one-cycle completion pulse
//   m_valid/ready/data/last       output byte stream (FIFO head)
//   mem_csb/web/addr/din          registered memory controls (active-low csb/web)
//   mem_dout                      memory read data
module cpu_mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int RAM_DEPTH  = 128,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  h_wr_valid,
  output logic                  h_wr_ready,
  input  logic [ADDR_WIDTH-1:0] h_wr_addr,
  input  logic [DATA_WIDTH-1:0] h_wr_data,
  input  logic                  pkt_go,
  input  logic [ADDR_WIDTH-1:0] pkt_base,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  pkt_busy,
  output logic                  pkt_done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  mem_csb,
  output logic                  mem_web,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  last_was_host;

  // Read pipeline: s1 = memory samples the read next edge, s2 = data on mem_dout now.
  logic                  rd_s1, rd_s2, last_s1, last_s2;
  logic [1:0]            inflight;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [1:0]            fifo_wp, fifo_rp;
  logic [2:0]            fifo_count;

  logic [3:0]            occupancy;
  logic                  rd_elig, host_grant, rd_grant, push, pop, load;

  assign inflight  = {1'b0, rd_s1} + {1'b0, rd_s2};
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign push      = rd_s2;
  assign pop       = m_valid && m_ready;

  assign h_wr_ready = host_grant;
  assign pkt_busy   = (state != IDLE);
  assign pkt_done   = (state == DONE);
  assign m_valid    = (fifo_count != 3'd0);
  assign m_data     = m_valid ? fifo_data[fifo_rp] : '0;
  assign m_last     = m_valid ? fifo_last[fifo_rp] : 1'b0;

  // Arbitration: reads only issue while every in-flight byte is guaranteed a
  // FIFO slot; on contention the most recently granted requester loses.
  always_comb begin
    rd_elig    = (state == STREAM) && (remaining != '0) && (occupancy < 4'd4);
    host_grant = 1'b0;
    rd_grant   = 1'b0;
    if (!rst0) begin
      if (h_wr_valid && rd_elig) begin
        host_grant = !last_was_host;
        rd_grant   = last_was_host;
      end else begin
        host_grant = h_wr_valid;
        rd_grant   = rd_elig;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_go) begin
          if (pkt_len != '0) begin
            load      = 1'b1;
            state_nxt = STREAM;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      STREAM: begin
        if (rd_grant && (remaining == LEN_WIDTH'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Leave as the final byte pops so pkt_done lands right after its handshake.
        if ((inflight == 2'd0) &&
            ((fifo_count == 3'd0) || ((fifo_count == 3'd1) && pop)))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      remaining     <= '0;
      last_was_host <= 1'b0;
      rd_s1         <= 1'b0;
      rd_s2         <= 1'b0;
      last_s1       <= 1'b0;
      last_s2       <= 1'b0;
      fifo_wp       <= '0;
      fifo_rp       <= '0;
      fifo_count    <= '0;
      mem_csb       <= 1'b1;
      mem_web       <= 1'b1;
      mem_addr      <= '0;
      mem_din       <= '0;
    end else begin
      state <= state_nxt;

      if (load) begin
        rd_ptr    <= pkt_base;
        remaining <= pkt_len;
      end else if (rd_grant) begin
        rd_ptr    <= (rd_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      if (host_grant || rd_grant) last_was_host <= host_grant;

      if (host_grant) begin
        mem_csb  <= 1'b0;
        mem_web  <= 1'b0;
        mem_addr <= h_wr_addr;
        mem_din  <= h_wr_data;
      end else if (rd_grant) begin
        mem_csb  <= 1'b0;
        mem_web  <= 1'b1;
        mem_addr <= rd_ptr;
      end else begin
        mem_csb  <= 1'b1;
        mem_web  <= 1'b1;
      end

      rd_s1   <= rd_grant;
      last_s1 <= rd_grant && (remaining == LEN_WIDTH'(1));
      rd_s2   <= rd_s1;
      last_s2 <= last_s1;

      if (push) fifo_wp <= fifo_wp + 1'b1;
      if (pop)  fifo_rp <= fifo_rp + 1'b1;
      fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
    end
  end

  // FIFO storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk0) begin
    if (!rst0 && push) begin
      fifo_data[fifo_wp] <= mem_dout;
      fifo_last[fifo_wp] <= last_s2;
    end
  end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb/tb_cpu_mem_ctrl.sv - randomized self-checking bench for cpu_mem_ctrl
module tb_cpu_mem_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
  localparam int LW    = AW + 1;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          h_wr_valid, h_wr_ready;
  logic [AW-1:0] h_wr_addr;
  logic [DW-1:0] h_wr_data;
  logic          pkt_go;
  logic [AW-1:0] pkt_base;
  logic [LW-1:0] pkt_len;
  logic          pkt_busy, pkt_done;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_data;
  logic          mem_csb, mem_web;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  always #5 clk0 = ~clk0;

  cpu_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .clk0(clk0), .rst0(rst0),
    .h_wr_valid(h_wr_valid), .h_wr_ready(h_wr_ready), .h_wr_addr(h_wr_addr), .h_wr_data(h_wr_data),
    .pkt_go(pkt_go), .pkt_base(pkt_base), .pkt_len(pkt_len),
    .pkt_busy(pkt_busy), .pkt_done(pkt_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .mem_csb(mem_csb), .mem_web(mem_web), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Single-port memory: samples controls on posedge, performs the op at the next negedge.
  logic [DW-1:0] ram [DEPTH];
  logic          q_csb, q_web;
  logic [AW-1:0] q_addr;
  logic [DW-1:0] q_din;

  always @(posedge clk0) begin
    q_csb  <= mem_csb;
    q_web  <= mem_web;
    q_addr <= mem_addr;
    q_din  <= mem_din;
  end

  always @(negedge clk0) begin
    if (q_csb === 1'b0) begin
      if (q_web === 1'b0) ram[q_addr] <= q_din;
      else                mem_dout    <= ram[q_addr];
    end
  end

  // Reference: what the memory holds after every accepted host write.
  logic [DW-1:0] shadow [DEPTH];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic host_write(input int a, input int d);
    bit done = 0;
    h_wr_valid = 1'b1;
    h_wr_addr  = AW'(a);
    h_wr_data  = DW'(d);
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk0);
      if (h_wr_ready) begin
        shadow[a] = DW'(d);
        done = 1;
      end
      @(posedge clk0); #1;
    end
    h_wr_valid = 1'b0;
    if (!done) check("host_write_timeout", 0, 1);
  endtask

  task automatic run_pkt(input int base, input int len, input int mode,
                         input bit contend, input bit go_busy, input bit chk_lat);
    int  idx = 0, last_hs = -1, first_rd = -1, first_valid = -1, maxc = 0;
    int  k = 0, n_reads = 0, prev_op = -1, viol = 0;
    bit  done_seen = 0, prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] new_val = DW'($urandom);
    pkt_base = AW'(base);
    pkt_len  = LW'(len);
    pkt_go   = 1'b1;
    @(posedge clk0); #1;
    pkt_go   = 1'b0;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (contend) begin
        h_wr_valid = 1'b1;
        h_wr_addr  = (k == 0) ? AW'((base + len - 1) % DEPTH) : AW'(100 + (k % 20));
        h_wr_data  = (k == 0) ? new_val : DW'($urandom);
      end
      if (go_busy && cyc == 3) begin
        pkt_base = AW'((base + 50) % DEPTH);
        pkt_len  = LW'(3);
        pkt_go   = 1'b1;
      end else begin
        pkt_go   = 1'b0;
      end
      @(negedge clk0);
      if (cyc == 0 && len > 0) check("busy_rise", pkt_busy, 1);
      if (int'(dut.fifo_count) > maxc) maxc = int'(dut.fifo_count);
      if (mem_csb == 1'b0) begin
        if (contend && n_reads > 0 && n_reads < len && int'(mem_web) == prev_op) viol++;
        if (mem_web) begin
          if (first_rd < 0) first_rd = cyc;
          n_reads++;
        end
        prev_op = int'(mem_web);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
      end
      if (contend && h_wr_valid && h_wr_ready) begin
        shadow[h_wr_addr] = h_wr_data;
        k++;
      end
      if (m_valid && m_ready) begin
        if (idx < len) begin
          check($sformatf("data[%0d]", idx), m_data, shadow[(base + idx) % DEPTH]);
          check($sformatf("last[%0d]", idx), m_last, (idx == len - 1));
        end else begin
          check("extra_byte", idx, len);
        end
        idx++;
        last_hs = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (pkt_done) begin
        done_seen = 1;
        if (len > 0) check("done_after_last", cyc, last_hs + 1);
        else         check("done_len0", cyc, 0);
      end
      @(posedge clk0); #1;
    end
    h_wr_valid = 1'b0;
    pkt_go     = 1'b0;
    check("done_seen", done_seen, 1);
    check("byte_count", idx, len);
    check("fifo_max_le4", (maxc <= 4), 1);
    if (len == 0) check("len0_no_valid", (first_valid < 0), 1);
    if (chk_lat) check("read_latency", first_valid - first_rd, 2);
    if (contend) begin
      check("alternate_grants", viol, 0);
      check("contend_new_value", shadow[(base + len - 1) % DEPTH], new_val);
    end
    @(negedge clk0);
    check("idle_after_done", {pkt_busy, pkt_done, m_valid}, 3'b000);
    @(posedge clk0); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {h_wr_ready, pkt_busy, pkt_done, m_valid, m_last}, 5'b0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_csb_web"}, {mem_csb, mem_web}, 2'b11);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_din"}, mem_din, 0);
  endtask

  initial begin
    int hs;
    int stale;
    rst0 = 1'b1; h_wr_valid = 1'b0; h_wr_addr = '0; h_wr_data = '0;
    pkt_go = 1'b0; pkt_base = '0; pkt_len = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk0);
    #1;
    @(negedge clk0);
    check_reset_outputs("reset");
    @(posedge clk0); #1;
    rst0 = 1'b0;

    for (int a = 0; a < DEPTH; a++) host_write(a, $urandom_range(0, 255));

    // Basic stream with latency check.
    for (int i = 0; i < 5; i++) host_write(10 + i, 8'hA0 + i);
    run_pkt(10, 5, 0, 0, 0, 1);

    // Wrap-around.
    host_write(126, 8'h11); host_write(127, 8'h22);
    host_write(0, 8'h33);   host_write(1, 8'h44);
    run_pkt(126, 4, 0, 0, 0, 1);

    // Backpressure 1,0,0,1.
    run_pkt(30, 8, 1, 0, 0, 0);

    // Contention with host held valid.
    run_pkt(40, 8, 0, 1, 0, 0);

    // Edge commands.
    run_pkt(5, 0, 0, 0, 0, 0);
    run_pkt(70, 8, 0, 0, 1, 0);
    run_pkt(0, 128, 0, 0, 0, 0);

    // Randomized packets.
    for (int r = 0; r < 6; r++)
      run_pkt($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), $urandom_range(0, 2), 0, 0, 0);

    // Reset mid-packet after 3 of 6 bytes.
    m_ready  = 1'b1;
    pkt_base = AW'(20);
    pkt_len  = LW'(6);
    pkt_go   = 1'b1;
    @(posedge clk0); #1;
    pkt_go = 1'b0;
    hs = 0;
    for (int c = 0; c < 100 && hs < 3; c++) begin
      @(negedge clk0);
      if (m_valid && m_ready) begin
        check("rst_pre_data", m_data, shadow[20 + hs]);
        hs++;
      end
      @(posedge clk0); #1;
    end
    check("rst_pre_count", hs, 3);
    rst0 = 1'b1;
    @(posedge clk0); #1;
    @(negedge clk0);
    check_reset_outputs("midrst");
    @(posedge clk0); #1;
    rst0 = 1'b0;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk0);
      if (m_valid || pkt_busy) stale++;
      @(posedge clk0); #1;
    end
    check("no_stale_after_rst", stale, 0);
    run_pkt(60, 6, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
